sd_wb_byte_bridge: RTL and testbench

//  32-bit Wishbone classic slave that serialises each bus cycle onto the controller's 8-bit register port.
//  - Output side drives we, addr and wdata into the register file.
//  - rdata is the register file's combinational byte read-back.
//  - Sits directly upstream of the register file.
//  - Bytes are always sequenced 3,2,1,0, so byte 0 (the cmd_start / ISR-clear trigger) is written last.
//    The argument register is therefore fully updated before the command launches.

---
 rtl/sd_bus_pkg.sv | 19 +
 rtl/sd_wb_byte_bridge.sv | 151 +++++++++++++++
 tb/tb_sd_wb_byte_bridge.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sd_bus_pkg.sv
// Shared types and constants for the SD controller's Wishbone bus bridge.
package sd_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } bridge_state_t;

  localparam int         BYTES_PER_WORD = 4;
  // Highest lane goes first so byte 0 (cmd_start / ISR-clear) lands last.
  localparam logic [1:0] FIRST_IDX      = 2'(BYTES_PER_WORD - 1);

  // Extract byte lane idx from a 32-bit word.
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/sd_wb_byte_bridge.sv
// Wishbone classic 32-bit slave serialising each bus cycle onto the
// controller's 8-bit register port, lanes 3,2,1,0, ack four cycles later.
// Optional feature: define SD_WB_SEL_EN to honour wb_sel_i on writes
// (unselected lanes keep their cycle but are not written).
module sd_wb_byte_bridge
  import sd_bus_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata
);

  localparam int HI_W = ADDR_W - 2;

  bridge_state_t   state_q, state_d;
  logic [1:0]      idx_q, idx_d, nidx;
  logic [HI_W-1:0] adr_q, adr_d;
  logic            we_q, we_d;
  logic [3:0]      sel_q, sel_d, sel_in;
  logic [31:0]     dat_q, dat_d;
  logic            ack_d, reg_we_q, reg_we_d;
  logic [31:0]     dat_o_d;
  logic [ADDR_W-1:0] reg_addr_d;
  logic [7:0]      reg_wdata_d;
  logic            start;
  logic            unused_ok;

`ifdef SD_WB_SEL_EN
  assign sel_in = wb_sel_i;
`else
  assign sel_in = 4'hF;
`endif

  // Word-offset bits are not used; the lane index replaces them.
  assign unused_ok = ^{wb_sel_i, wb_adr_i[1:0]};

  assign start = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign nidx  = idx_q - 2'd1;

  // The registered strobe is cut the moment the master drops the cycle, so an
  // abort in the byte-0 slot can never fire cmd_start.
  assign reg_we = reg_we_q & wb_cyc_i;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept, walk four lanes (or abort), one ack cycle.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = XFER;
      XFER: begin
        if (!wb_cyc_i)          state_d = IDLE;
        else if (idx_q == 2'd0) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the latched request, lane index and registered outputs.
  always_comb begin
    idx_d       = idx_q;
    adr_d       = adr_q;
    we_d        = we_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    ack_d       = 1'b0;
    dat_o_d     = wb_dat_o;
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr;
    reg_wdata_d = reg_wdata;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          adr_d       = wb_adr_i[ADDR_W-1:2];
          we_d        = wb_we_i;
          sel_d       = sel_in;
          dat_d       = wb_dat_i;
          idx_d       = FIRST_IDX;
          reg_addr_d  = {wb_adr_i[ADDR_W-1:2], FIRST_IDX};
          reg_wdata_d = byte_of(wb_dat_i, FIRST_IDX);
          reg_we_d    = wb_we_i & sel_in[FIRST_IDX];
        end
      end
      XFER: begin
        if (!wb_cyc_i) begin
          idx_d = FIRST_IDX;
        end else begin
          if (!we_q) dat_o_d[8*idx_q +: 8] = reg_rdata;
          if (idx_q == 2'd0) begin
            ack_d = 1'b1;
          end else begin
            idx_d       = nidx;
            reg_addr_d  = {adr_q, nidx};
            reg_wdata_d = byte_of(dat_q, nidx);
            reg_we_d    = we_q & sel_q[nidx];
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= FIRST_IDX;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      dat_q     <= '0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      reg_we_q  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      idx_q     <= idx_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      wb_ack_o  <= ack_d;
      wb_dat_o  <= dat_o_d;
      reg_we_q  <= reg_we_d;
      reg_addr  <= reg_addr_d;
      reg_wdata <= reg_wdata_d;
    end
  end

endmodule

// File: tb/tb_sd_wb_byte_bridge.sv
// Directed bench for sd_wb_byte_bridge with a byte-wide register file model.
module tb_sd_wb_byte_bridge;

  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]        wb_sel_i;
  logic [ADDR_W-1:0] wb_adr_i;
  logic [31:0]       wb_dat_i, wb_dat_o;
  logic              wb_ack_o, reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata, reg_rdata;

  always #5 clk = ~clk;

  sd_wb_byte_bridge #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata)
  );

  // Register file model: combinational read, clocked byte write, write log.
  logic [7:0]  mem [0:127];
  logic [14:0] wlog [$];

  assign reg_rdata = mem[reg_addr];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
      mem[7'h33] <= 8'h11;
      mem[7'h32] <= 8'h22;
      mem[7'h31] <= 8'h33;
      mem[7'h30] <= 8'h44;
    end else if (reg_we) begin
      mem[reg_addr] <= reg_wdata;
      wlog.push_back({reg_addr, reg_wdata});
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag, input int i, input logic [6:0] a, input logic [7:0] d);
    check(tag, (i < wlog.size()) ? {17'd0, wlog[i]} : 32'hFFFF_FFFF, {17'd0, a, d});
  endtask

  // Call #1 after a posedge. Returns ack latency in cycles (0 = none in budget).
  task automatic bus_cycle(input logic we, input logic [6:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input bit hold,
                           output int lat, output logic [31:0] rd);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    lat = 0;
    rd  = 'x;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin
        lat = c;
        rd  = wb_dat_o;
        break;
      end
    end
    if (!hold) begin
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ack"},   32'(wb_ack_o),  32'd0);
    check({pfx, "_dato"},  wb_dat_o,       32'd0);
    check({pfx, "_we"},    32'(reg_we),    32'd0);
    check({pfx, "_addr"},  32'(reg_addr),  32'd0);
    check({pfx, "_wdata"}, 32'(reg_wdata), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    bit          got_ack;

    rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_sel_i = 4'h0; wb_adr_i = '0;   wb_dat_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: full write, lanes 3..0, ack at T+5, one cycle only.
    wlog.delete();
    bus_cycle(1'b1, 7'h04, 32'hA1B2C3D4, 4'hF, 1'b0, lat, rd);
    check("t1_lat", 32'(lat), 32'd5);
    @(posedge clk); #1;
    check("t1_ack_once", 32'(wb_ack_o), 32'd0);
    check("t1_nwr", 32'(wlog.size()), 32'd4);
    check_log("t1_w0", 0, 7'h07, 8'hA1);
    check_log("t1_w1", 1, 7'h06, 8'hB2);
    check_log("t1_w2", 2, 7'h05, 8'hC3);
    check_log("t1_w3", 3, 7'h04, 8'hD4);

    // 2: read assembles bytes, no writes, data held after ack.
    wlog.delete();
    bus_cycle(1'b0, 7'h30, 32'h0, 4'hF, 1'b0, lat, rd);
    check("t2_lat", 32'(lat), 32'd5);
    check("t2_rdata", rd, 32'h11223344);
    check("t2_nwr", 32'(wlog.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t2_hold", wb_dat_o, 32'h11223344);

    // 3: byte-lane select 0101.
    wlog.delete();
    bus_cycle(1'b1, 7'h08, 32'hDEADBEEF, 4'b0101, 1'b0, lat, rd);
    check("t3_lat", 32'(lat), 32'd5);
`ifdef SD_WB_SEL_EN
    check("t3_nwr", 32'(wlog.size()), 32'd2);
    check_log("t3_w0", 0, 7'h0A, 8'hAD);
    check_log("t3_w1", 1, 7'h08, 8'hEF);
`else
    check("t3_nwr", 32'(wlog.size()), 32'd4);
    check_log("t3_w0", 0, 7'h0B, 8'hDE);
    check_log("t3_w1", 1, 7'h0A, 8'hAD);
    check_log("t3_w2", 2, 7'h09, 8'hBE);
    check_log("t3_w3", 3, 7'h08, 8'hEF);
`endif
    @(posedge clk); #1;

    // 4: abort after two bytes; byte 0 must never be written.
    wlog.delete();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 7'h0C; wb_dat_i = 32'h01020304; wb_sel_i = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    got_ack = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      got_ack |= wb_ack_o;
    end
    check("t4_noack", 32'(got_ack), 32'd0);
    check("t4_nwr", 32'(wlog.size()), 32'd2);
    check_log("t4_w0", 0, 7'h0F, 8'h01);
    check_log("t4_w1", 1, 7'h0E, 8'h02);
    check("t4_byte1", 32'(mem[7'h0D]), 32'd0);
    check("t4_byte0", 32'(mem[7'h0C]), 32'd0);

    // 5: strobe held through ack must not re-trigger.
    wlog.delete();
    bus_cycle(1'b1, 7'h10, 32'h55667788, 4'hF, 1'b1, lat, rd);
    check("t5_lat", 32'(lat), 32'd5);
    @(posedge clk); #1;
    check("t5_idle_ack", 32'(wb_ack_o), 32'd0);
    check("t5_idle_we", 32'(reg_we), 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1;
    check("t5_idle_we2", 32'(reg_we), 32'd0);
    check("t5_nwr", 32'(wlog.size()), 32'd4);
    bus_cycle(1'b0, 7'h04, 32'h0, 4'hF, 1'b0, lat, rd);
    check("t5_rd_lat", 32'(lat), 32'd5);
    check("t5_rd_data", rd, 32'hA1B2C3D4);
    @(posedge clk); #1;

    // 6: reset in the idx=1 slot, then a clean write.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 7'h14; wb_dat_i = 32'h99AABBCC; wb_sel_i = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("t6_rst");
    rst = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1;
    check("t6_noack", 32'(wb_ack_o), 32'd0);
    wlog.delete();
    bus_cycle(1'b1, 7'h18, 32'h0BADF00D, 4'hF, 1'b0, lat, rd);
    check("t6_lat", 32'(lat), 32'd5);
    check("t6_nwr", 32'(wlog.size()), 32'd4);
    check_log("t6_w0", 0, 7'h1B, 8'h0B);
    check_log("t6_w1", 1, 7'h1A, 8'hAD);
    check_log("t6_w2", 2, 7'h19, 8'hF0);
    check_log("t6_w3", 3, 7'h18, 8'h0D);
    @(posedge clk); #1;
    bus_cycle(1'b0, 7'h18, 32'h0, 4'hF, 1'b0, lat, rd);
    check("t6_rd_data", rd, 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
